// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader and the instruction store.
// Holds the loader state encoding, frame field names and the default store size.
package imem_pkg;

  localparam int MEM_BYTES_DEFAULT = 128;
  localparam int LEN_W             = 16;
  localparam int BYTE_CNT_W        = 17;
  localparam int TOTAL_W           = LEN_W + 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_CHECK,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  typedef enum logic [1:0] {
    FLD_LEN_LO,
    FLD_LEN_HI,
    FLD_DATA,
    FLD_CSUM
  } frame_field_t;

endpackage

// File: rtl/imem_loader.sv
// Framed byte-stream programmer for the instruction store: LEN_LO, LEN_HI, 4*N bytes, XOR CSUM.
// Keeps the CPU held until a frame completes with a matching checksum.
module imem_loader
  import imem_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int ADDR_W    = $clog2(MEM_BYTES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              inValid,
  input  logic [7:0]        inByte,
  output logic              inReady,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [7:0]        memData,
  output logic              cpuHold,
  output logic              loadDone,
  output logic              loadErr
);

  localparam logic [TOTAL_W-1:0] CAPACITY = TOTAL_W'(MEM_BYTES);

  state_t                  state_reg, state_next;
  logic [LEN_W-1:0]        len_reg;
  logic [BYTE_CNT_W-1:0]   byte_cnt_reg;
  logic [ADDR_W-1:0]       addr_cnt_reg;
  logic [7:0]              xor_reg;

  logic                    arm;
  logic                    take;
  logic [TOTAL_W-1:0]      total_bytes;
  logic [BYTE_CNT_W-1:0]   byte_cnt_inc;
  logic                    last_byte;

  assign take         = inValid & inReady;
  assign total_bytes  = {len_reg, 2'b00};
  assign byte_cnt_inc = byte_cnt_reg + 1'b1;
  assign last_byte    = (total_bytes == {1'b0, byte_cnt_inc});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    inReady    = 1'b0;
    cpuHold    = 1'b1;
    loadDone   = 1'b0;
    loadErr    = 1'b0;
    arm        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          arm        = 1'b1;
          state_next = ST_LEN0;
        end
      end
      ST_LEN0: begin
        inReady = 1'b1;
        if (inValid) state_next = ST_LEN1;
      end
      ST_LEN1: begin
        inReady = 1'b1;
        if (inValid) state_next = ST_CHECK;
      end
      ST_CHECK: begin
        // Oversize frames are rejected here, so the address counter never wraps.
        if (total_bytes > CAPACITY)     state_next = ST_ERR;
        else if (total_bytes == '0)     state_next = ST_CSUM;
        else                            state_next = ST_DATA;
      end
      ST_DATA: begin
        inReady = 1'b1;
        if (inValid && last_byte) state_next = ST_CSUM;
      end
      ST_CSUM: begin
        inReady = 1'b1;
        if (inValid) state_next = (inByte == xor_reg) ? ST_DONE : ST_ERR;
      end
      ST_DONE: begin
        cpuHold  = 1'b0;
        loadDone = 1'b1;
        if (start) begin
          arm        = 1'b1;
          state_next = ST_LEN0;
        end
      end
      ST_ERR: begin
        loadErr = 1'b1;
        if (start) begin
          arm        = 1'b1;
          state_next = ST_LEN0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_reg      <= '0;
      byte_cnt_reg <= '0;
      addr_cnt_reg <= '0;
      xor_reg      <= '0;
      memWe        <= 1'b0;
      memAddr      <= '0;
      memData      <= '0;
    end else begin
      memWe <= 1'b0;
      if (arm) begin
        len_reg      <= '0;
        byte_cnt_reg <= '0;
        addr_cnt_reg <= '0;
        xor_reg      <= '0;
      end
      if (take && state_reg == ST_LEN0) len_reg[7:0]  <= inByte;
      if (take && state_reg == ST_LEN1) len_reg[15:8] <= inByte;
      if (take && state_reg == ST_DATA) begin
        memWe        <= 1'b1;
        memAddr      <= addr_cnt_reg;
        memData      <= inByte;
        addr_cnt_reg <= addr_cnt_reg + 1'b1;
        byte_cnt_reg <= byte_cnt_inc;
        xor_reg      <= xor_reg ^ inByte;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: good, bad, oversize and empty frames,
// source stalls with a mid-frame start, and reset in the middle of DATA.
module tb_imem_loader;

  localparam int ADDR_W = 7;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              inValid = 1'b0;
  logic [7:0]        inByte = 8'h00;
  logic              inReady;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [7:0]        memData;
  logic              cpuHold;
  logic              loadDone;
  logic              loadErr;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]        prog [8] = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
  localparam logic [7:0] GOOD_CSUM = 8'hB0;

  int                wr_n = 0;
  logic [ADDR_W-1:0] wr_addr [64];
  logic [7:0]        wr_data [64];

  imem_loader #(.MEM_BYTES(128), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .inValid  (inValid),
    .inByte   (inByte),
    .inReady  (inReady),
    .memWe    (memWe),
    .memAddr  (memAddr),
    .memData  (memData),
    .cpuHold  (cpuHold),
    .loadDone (loadDone),
    .loadErr  (loadErr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (memWe) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] = memAddr;
        wr_data[wr_n] = memData;
      end
      wr_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit stall);
    int guard;
    guard = 0;
    if (stall) begin
      inValid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    inValid = 1'b1;
    inByte  = b;
    while (!inReady && guard < 20) begin
      tick();
      guard++;
    end
    if (!inReady) chk("ready_timeout", 32'(inReady), 32'd1);
    tick();
    inValid = 1'b0;
  endtask

  task automatic load_frame(input logic [15:0] n, input int nbytes, input logic [7:0] csum,
                            input bit stall, input bit mid_start);
    wr_n = 0;
    pulse_start();
    send(n[7:0], stall);
    send(n[15:8], stall);
    for (int i = 0; i < nbytes; i++) begin
      if (mid_start && i == 4) pulse_start();
      send(prog[i], stall);
    end
    send(csum, stall);
  endtask

  task automatic check_prog_writes(input string tag);
    chk({tag, "_wr_count"}, 32'(wr_n), 32'd8);
    for (int i = 0; i < 8 && i < wr_n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 32'(wr_addr[i]), 32'(i));
      chk($sformatf("%s_data%0d", tag, i), 32'(wr_data[i]), 32'(prog[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    chk("rst_inReady",  32'(inReady),  32'd0);
    chk("rst_memWe",    32'(memWe),    32'd0);
    chk("rst_memAddr",  32'(memAddr),  32'd0);
    chk("rst_memData",  32'(memData),  32'd0);
    chk("rst_cpuHold",  32'(cpuHold),  32'd1);
    chk("rst_loadDone", 32'(loadDone), 32'd0);
    chk("rst_loadErr",  32'(loadErr),  32'd0);
    reset = 1'b0;
    tick();
    chk("idle_cpuHold", 32'(cpuHold), 32'd1);
    $display("txn reset: done");

    // Good two-word frame
    load_frame(16'd2, 8, GOOD_CSUM, 1'b0, 1'b0);
    chk("good_loadDone", 32'(loadDone), 32'd1);
    chk("good_cpuHold",  32'(cpuHold),  32'd0);
    chk("good_inReady",  32'(inReady),  32'd0);
    chk("good_loadErr",  32'(loadErr),  32'd0);
    check_prog_writes("good");
    tick();
    tick();
    chk("hold_memWe",   32'(memWe),   32'd0);
    chk("hold_memAddr", 32'(memAddr), 32'd7);
    chk("hold_memData", 32'(memData), 32'h00);
    $display("txn good frame: writes=%0d done=%0b hold=%0b", wr_n, loadDone, cpuHold);

    // Bad checksum
    load_frame(16'd2, 8, ~GOOD_CSUM, 1'b0, 1'b0);
    check_prog_writes("bad");
    chk("bad_loadErr",  32'(loadErr),  32'd1);
    chk("bad_loadDone", 32'(loadDone), 32'd0);
    chk("bad_cpuHold",  32'(cpuHold),  32'd1);
    chk("bad_inReady",  32'(inReady),  32'd0);
    $display("txn bad csum: writes=%0d err=%0b", wr_n, loadErr);

    // Oversize: 33 words = 132 bytes
    wr_n = 0;
    pulse_start();
    send(8'd33, 1'b0);
    send(8'd0, 1'b0);
    chk("over_check_inReady", 32'(inReady), 32'd0);
    chk("over_check_loadErr", 32'(loadErr), 32'd0);
    tick();
    chk("over_loadErr", 32'(loadErr), 32'd1);
    chk("over_inReady", 32'(inReady), 32'd0);
    chk("over_cpuHold", 32'(cpuHold), 32'd1);
    tick();
    chk("over_writes",  32'(wr_n),    32'd0);
    $display("txn oversize: err=%0b writes=%0d", loadErr, wr_n);

    // Zero length, matching and mismatching checksum
    load_frame(16'd0, 0, 8'h00, 1'b0, 1'b0);
    chk("zero_ok_loadDone", 32'(loadDone), 32'd1);
    chk("zero_ok_cpuHold",  32'(cpuHold),  32'd0);
    chk("zero_ok_writes",   32'(wr_n),     32'd0);
    $display("txn zero len csum=00: done=%0b", loadDone);
    load_frame(16'd0, 0, 8'h01, 1'b0, 1'b0);
    chk("zero_bad_loadErr", 32'(loadErr),  32'd1);
    chk("zero_bad_loadDone", 32'(loadDone), 32'd0);
    chk("zero_bad_writes",  32'(wr_n),     32'd0);
    $display("txn zero len csum=01: err=%0b", loadErr);

    // Source stalls with a start pulse mid-DATA
    load_frame(16'd2, 8, GOOD_CSUM, 1'b1, 1'b1);
    check_prog_writes("stall");
    chk("stall_loadDone", 32'(loadDone), 32'd1);
    chk("stall_cpuHold",  32'(cpuHold),  32'd0);
    $display("txn stalled frame: writes=%0d done=%0b", wr_n, loadDone);

    // Reset after three data bytes
    wr_n = 0;
    pulse_start();
    send(8'd2, 1'b0);
    send(8'd0, 1'b0);
    for (int i = 0; i < 3; i++) send(prog[i], 1'b0);
    chk("pre_rst_memWe", 32'(memWe), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_memWe",    32'(memWe),    32'd0);
    chk("midrst_cpuHold",  32'(cpuHold),  32'd1);
    chk("midrst_inReady",  32'(inReady),  32'd0);
    chk("midrst_loadDone", 32'(loadDone), 32'd0);
    chk("midrst_loadErr",  32'(loadErr),  32'd0);
    tick();
    reset = 1'b0;
    tick();
    $display("txn mid reset: writes before reset=%0d", wr_n);
    load_frame(16'd2, 8, GOOD_CSUM, 1'b0, 1'b0);
    check_prog_writes("reload");
    chk("reload_loadDone", 32'(loadDone), 32'd1);
    chk("reload_cpuHold",  32'(cpuHold),  32'd0);
    $display("txn reload: writes=%0d done=%0b", wr_n, loadDone);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
